// File: rtl/stopwatch_core.sv
// stopwatch_core: hours/minutes/seconds stopwatch with prescaler, up/down
// counting, expiry, preset load and lap (display freeze). Outputs are
// packed BCD for the on-screen digit renderer.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ss                 start/stop request (acted on at rising edge)
//   lap                lap toggle (acted on at rising edge)
//   mode               0 = count up, 1 = count down (latched on start)
//   load               preset strobe (ignored while running)
//   ld_h, ld_m, ld_s   preset values, packed BCD
//   th, tm, ts         displayed hours/minutes/seconds, packed BCD
//   running            high in RUN
//   done               high in EXPIRED (one cycle behind the state register)
//   lap_active         high while the display is frozen
module stopwatch_core #(
  parameter int TICK_DIV = 25000000,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ss,
  input  logic       lap,
  input  logic       mode,
  input  logic       load,
  input  logic [7:0] ld_h,
  input  logic [7:0] ld_m,
  input  logic [7:0] ld_s,
  output logic [7:0] th,
  output logic [7:0] tm,
  output logic [7:0] ts,
  output logic       running,
  output logic       done,
  output logic       lap_active
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] H_TOP = 8'(((HOUR_MAX - 1) / 10) * 16 + (HOUR_MAX - 1) % 10);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_EXP  = 2'd2;

  function automatic logic [7:0] clamp_nib(input logic [7:0] v);
    return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
  endfunction

  function automatic logic [7:0] sat_ms(input logic [7:0] v);
    logic [7:0] c;
    c = clamp_nib(v);
    return (c > 8'h59) ? 8'h59 : c;
  endfunction

  function automatic logic [7:0] sat_h(input logic [7:0] v);
    logic [7:0] c;
    c = clamp_nib(v);
    return (c > H_TOP) ? H_TOP : c;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [1:0]    state;
  logic          dir;
  logic [PW-1:0] presc;
  logic [7:0]    h_p0, m_p0, s_p0;
  logic [7:0]    h_n, m_n, s_n;
  logic          ss_q, lap_q;
  logic          ss_edge, lap_edge, tick, cnt_zero, step_zero;

  assign ss_edge   = ss & ~ss_q;
  assign lap_edge  = lap & ~lap_q;
  assign tick      = (state == ST_RUN) && (presc == PRE_MAX);
  assign cnt_zero  = ({h_p0, m_p0, s_p0} == 24'd0);
  assign step_zero = ({h_n, m_n, s_n} == 24'd0);
  assign running   = (state == ST_RUN);

  // One-second step of the live count. Loaded values are sanitised, so the
  // hour field never exceeds H_TOP and down-steps never start from zero.
  always_comb begin
    s_n = s_p0;
    m_n = m_p0;
    h_n = h_p0;
    if (!dir) begin
      if (s_p0 == 8'h59) begin
        s_n = 8'h00;
        if (m_p0 == 8'h59) begin
          m_n = 8'h00;
          h_n = (h_p0 == H_TOP) ? 8'h00 : bcd_inc(h_p0);
        end else begin
          m_n = bcd_inc(m_p0);
        end
      end else begin
        s_n = bcd_inc(s_p0);
      end
    end else begin
      if (s_p0 == 8'h00) begin
        s_n = 8'h59;
        if (m_p0 == 8'h00) begin
          m_n = 8'h59;
          h_n = bcd_dec(h_p0);
        end else begin
          m_n = bcd_dec(m_p0);
        end
      end else begin
        s_n = bcd_dec(s_p0);
      end
    end
  end

  // Stage p0: control state, prescaler and live count
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_STOP;
      dir   <= 1'b0;
      presc <= '0;
      h_p0  <= 8'h00;
      m_p0  <= 8'h00;
      s_p0  <= 8'h00;
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      ss_q  <= ss;
      lap_q <= lap;
      if (state == ST_RUN) begin
        if (tick) begin
          presc <= '0;
          h_p0  <= h_n;
          m_p0  <= m_n;
          s_p0  <= s_n;
        end else begin
          presc <= presc + 1'b1;
        end
        // A stop request wins over an expiry falling in the same cycle.
        if (ss_edge)
          state <= ST_STOP;
        else if (tick && dir && step_zero)
          state <= ST_EXP;
      end else if (load) begin
        h_p0  <= sat_h(ld_h);
        m_p0  <= sat_ms(ld_m);
        s_p0  <= sat_ms(ld_s);
        presc <= '0;
        state <= ST_STOP;
      end else if (ss_edge) begin
        if (state == ST_STOP) begin
          // Counting down from zero would expire immediately; refuse the start.
          if (!(mode && cnt_zero)) begin
            state <= ST_RUN;
            dir   <= mode;
          end
        end else begin
          state <= ST_STOP;
        end
      end
    end
  end

  // Stage p1: displayed values, lap freeze and expiry flag
  always_ff @(posedge clk) begin
    if (reset) begin
      th         <= 8'h00;
      tm         <= 8'h00;
      ts         <= 8'h00;
      done       <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      if (lap_edge)
        lap_active <= ~lap_active;
      // Freeze follows the registered flag so the snapshot is the value
      // already on the display in the cycle after the lap edge.
      if (!lap_active) begin
        th <= h_p0;
        tm <= m_p0;
        ts <= s_p0;
      end
      done <= (state == ST_EXP);
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: a seconds-based reference model
// predicts the outputs for every clock cycle, the driver pushes predictions
// into a queue and a negedge monitor pops and compares them.
module tb_stopwatch_core;

  localparam int TICK_DIV = 4;
  localparam int HOUR_MAX = 24;
  localparam int DAY = HOUR_MAX * 3600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ss = 1'b0, lap = 1'b0, mode = 1'b0, load = 1'b0;
  logic [7:0] ld_h = 8'h00, ld_m = 8'h00, ld_s = 8'h00;
  logic [7:0] th, tm, ts;
  logic       running, done, lap_active;

  stopwatch_core #(.TICK_DIV(TICK_DIV), .HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk), .reset(reset), .ss(ss), .lap(lap), .mode(mode), .load(load),
    .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
    .th(th), .tm(tm), .ts(ts),
    .running(running), .done(done), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] th, tm, ts;
    logic       run, dn, lp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  // Reference model state: the count is kept as total seconds.
  int m_st;     // 0 stopped, 1 running, 2 expired
  int m_dir, m_pre, m_secs, m_disp;
  bit m_done, m_ssq, m_lapq, m_lapa;

  function automatic int san(input logic [7:0] v, input int maxv);
    int hi, lo, r;
    hi = (v[7:4] > 9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 9) ? 9 : int'(v[3:0]);
    r = hi * 10 + lo;
    return (r > maxv) ? maxv : r;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic model_step();
    bit ss_e, lap_e, tk;
    exp_t e;
    if (reset) begin
      m_st = 0; m_dir = 0; m_pre = 0; m_secs = 0; m_disp = 0;
      m_done = 0; m_ssq = 0; m_lapq = 0; m_lapa = 0;
    end else begin
      ss_e  = ss && !m_ssq;
      lap_e = lap && !m_lapq;
      m_ssq = ss;
      m_lapq = lap;
      if (!m_lapa) m_disp = m_secs;
      m_done = (m_st == 2);
      if (lap_e) m_lapa = !m_lapa;
      if (m_st == 1) begin
        tk = (m_pre == TICK_DIV - 1);
        if (tk) begin
          m_pre = 0;
          m_secs = m_dir ? m_secs - 1 : (m_secs + 1) % DAY;
        end else begin
          m_pre++;
        end
        if (ss_e) m_st = 0;
        else if (tk && m_dir == 1 && m_secs == 0) m_st = 2;
      end else if (load) begin
        m_secs = san(ld_h, HOUR_MAX - 1) * 3600 + san(ld_m, 59) * 60 + san(ld_s, 59);
        m_pre = 0;
        m_st = 0;
      end else if (ss_e) begin
        if (m_st == 0) begin
          if (!(mode && m_secs == 0)) begin
            m_st = 1;
            m_dir = mode;
          end
        end else begin
          m_st = 0;
        end
      end
    end
    e.cyc = cycle;
    e.th  = to_bcd(m_disp / 3600);
    e.tm  = to_bcd((m_disp / 60) % 60);
    e.ts  = to_bcd(m_disp % 60);
    e.run = (m_st == 1);
    e.dn  = m_done;
    e.lp  = m_lapa;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cycle++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_ss();
    ss = 1'b1; step();
    ss = 1'b0; step();
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step();
    lap = 1'b0; step();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ld_h = h; ld_m = m; ld_s = s;
    load = 1'b1; step();
    load = 1'b0; step();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (th !== e.th || tm !== e.tm || ts !== e.ts || running !== e.run ||
          done !== e.dn || lap_active !== e.lp) begin
        errors++;
        if (errors <= 25)
          $display("FAIL outputs cycle %0d: got %h:%h:%h run=%b done=%b lap=%b, expected %h:%h:%h run=%b done=%b lap=%b",
                   e.cyc, th, tm, ts, running, done, lap_active,
                   e.th, e.tm, e.ts, e.run, e.dn, e.lp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then basic up-count from zero.
    reset = 1'b1; run(3);
    reset = 1'b0; run(2);
    pulse_ss(); run(40);
    pulse_ss(); run(3);

    // Hour wrap in up mode.
    do_load(8'h23, 8'h59, 8'h58);
    mode = 1'b0; pulse_ss(); run(8 * TICK_DIV + 2);
    pulse_ss(); run(3);

    // Count-down to expiry, then clear with ss.
    mode = 1'b1; do_load(8'h00, 8'h01, 8'h02);
    pulse_ss(); run(62 * TICK_DIV + 6);
    pulse_ss(); run(3);

    // Lap freeze and release.
    mode = 1'b0; do_load(8'h00, 8'h00, 8'h00);
    pulse_ss(); run(3 * TICK_DIV - 1);
    pulse_lap(); run(5 * TICK_DIV);
    pulse_lap(); run(4);
    pulse_ss(); run(2);

    // Pause/resume keeps the partial second; reset mid-run.
    pulse_ss(); run(9);
    pulse_ss(); run(20);
    pulse_ss(); run(10);
    reset = 1'b1; step();
    reset = 1'b0; run(3);

    // Sanitising, refused down-start at zero, load beats ss.
    do_load(8'h7A, 8'h9F, 8'h99); run(2);
    mode = 1'b1; do_load(8'h00, 8'h00, 8'h00);
    pulse_ss(); run(6);
    mode = 1'b0;
    ld_h = 8'h01; ld_m = 8'h02; ld_s = 8'h03;
    load = 1'b1; ss = 1'b1; step();
    load = 1'b0; ss = 1'b0; run(6);

    // ss held high through reset gives an edge right after reset.
    ss = 1'b1; reset = 1'b1; run(2);
    reset = 1'b0; run(6);
    ss = 1'b0; run(2);

    // Randomised traffic.
    for (int i = 0; i < 20000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 15) ss = ~ss;
      else if (r < 22) lap = ~lap;
      else if (r < 30) mode = ~mode;
      load  = ($urandom_range(0, 99) < 2);
      reset = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ld_h = 8'h00;
        ld_m = 8'($urandom_range(0, 2));
        ld_s = 8'($urandom);
      end else begin
        ld_h = 8'($urandom);
        ld_m = 8'($urandom);
        ld_s = 8'($urandom);
      end
      step();
    end
    reset = 1'b0; load = 1'b0; ss = 1'b0; lap = 1'b0;
    run(4);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
